// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: one-shot (sticky level irq) or auto-reload (1-cycle pulse).
// Registers: CTRL {IM, MODE[1:0], EN}, PRESET, COUNT (read-only).
module timer_dev #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} st_e;

  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

  st_e         st_q, st_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic [15:0] ps_q, ps_d;
  logic        tick;

  assign tick = (ps_q == PS_MAX);

  always_comb begin
    st_d     = st_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;
    ps_d     = ps_q;
    case (st_q)
      IDLE: if (ctrl_q[0]) st_d = LOAD;
      LOAD: begin
        count_d = (preset_q == 32'd0) ? 32'd1 : preset_q;
        ps_d    = 16'd0;
        st_d    = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          st_d = IDLE;
        end else begin
          ps_d = tick ? 16'd0 : ps_q + 16'd1;
          if (tick) begin
            if (count_q > 32'd1) begin
              count_d = count_q - 32'd1;
            end else begin
              count_d = 32'd0;
              st_d    = INT;
            end
          end
        end
      end
      INT: begin
        if (ctrl_q[2:1] == 2'd1) begin
          st_d = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          pend_d    = 1'b1;
          st_d      = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
    // Software writes land after the hardware update so they win a same-cycle collision.
    if (we && addr == 2'd0) begin
      ctrl_d = wdata[3:0];
      pend_d = 1'b0;
    end
    if (we && addr == 2'd1) begin
      preset_d = wdata;
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
      ps_q     <= 16'd0;
    end else begin
      st_q     <= st_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      ps_q     <= ps_d;
    end
  end

  always_comb begin
    case (addr)
      2'd0:    rdata = {28'd0, ctrl_q};
      2'd1:    rdata = preset_q;
      2'd2:    rdata = count_q;
      default: rdata = 32'd0;
    endcase
  end

  assign irq = ctrl_q[3] & (pend_q | (st_q == INT));
endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: two instances (PRESCALE 1 and 4) on a shared bus, checked
// every cycle against an elapsed-time model, plus directed literal expectations.
module tb_timer_dev;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata1, rdata4;
  logic        irq1, irq4;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  longint edge_n = 0;

  always #5 clk = ~clk;

  timer_dev #(.PRESCALE(1)) dut1 (.clk(clk), .reset(reset), .addr(addr), .we(we),
                                  .wdata(wdata), .rdata(rdata1), .irq(irq1));
  timer_dev #(.PRESCALE(4)) dut4 (.clk(clk), .reset(reset), .addr(addr), .we(we),
                                  .wdata(wdata), .rdata(rdata4), .irq(irq4));

  // ph: 0 idle, 1 load, 2 counting, 3 expired. Count is derived from elapsed edges.
  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    bit          pend;
    int          ph;
    longint      t0;
    longint      n;
  } mdl_t;

  mdl_t m [2];
  int   pv [2] = '{1, 4};

  function automatic mdl_t step(mdl_t s, int p, logic rst, logic w, logic [1:0] a,
                                logic [31:0] d, longint e);
    mdl_t r = s;
    if (rst) begin
      r.ctrl = 4'd0; r.preset = 32'd0; r.count = 32'd0; r.pend = 1'b0;
      r.ph = 0; r.t0 = 0; r.n = 0;
      return r;
    end
    case (s.ph)
      0: if (s.ctrl[0]) r.ph = 1;
      1: begin
        r.n = (s.preset == 32'd0) ? 1 : longint'(s.preset);
        r.t0 = e; r.count = 32'(r.n); r.ph = 2;
      end
      2: begin
        if (!s.ctrl[0]) r.ph = 0;
        else if (e - s.t0 >= s.n * p) begin r.count = 32'd0; r.ph = 3; end
        else r.count = 32'(s.n - (e - s.t0) / p);
      end
      default: begin
        if (s.ctrl[2:1] == 2'd1) r.ph = 1;
        else begin r.ctrl[0] = 1'b0; r.pend = 1'b1; r.ph = 0; end
      end
    endcase
    if (w && a == 2'd0) begin r.ctrl = d[3:0]; r.pend = 1'b0; end
    if (w && a == 2'd1) begin r.preset = d; r.pend = 1'b0; end
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(mdl_t s, logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, s.ctrl};
      2'd1:    return s.preset;
      2'd2:    return s.count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) m[i] = step(m[i], pv[i], reset, we, addr, wdata, edge_n);
    edge_n++;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mdl_rdata_p1", rdata1, exp_rd(m[0], addr));
      chk("mdl_irq_p1", {31'd0, irq1}, {31'd0, m[0].ctrl[3] & (m[0].pend | (m[0].ph == 3))});
      chk("mdl_rdata_p4", rdata4, exp_rd(m[1], addr));
      chk("mdl_irq_p4", {31'd0, irq4}, {31'd0, m[1].ctrl[3] & (m[1].pend | (m[1].ph == 3))});
    end
  end

  task automatic cyc(int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    cyc(1);
    we = 1'b0;
  endtask

  task automatic rd(logic [1:0] a, output logic [31:0] v);
    addr = a; #1; v = rdata1;
  endtask

  task automatic rst();
    reset = 1'b1; cyc(1); reset = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    cyc(2);
    reset = 1'b0;
    cmp_en = 1'b1;

    // Reset in the middle of a mode-1 count
    wr(1, 5); wr(0, 32'hB); cyc(3);
    reset = 1'b1; cyc(1); reset = 1'b0;
    for (int a = 0; a < 4; a++) begin rd(2'(a), v); chk("rst_rd", v, 0); end
    chk("rst_irq", {31'd0, irq1}, 0);

    // One-shot, PRESET=3
    rst(); wr(1, 3); wr(0, 32'h9); addr = 2'd2;
    for (int j = 1; j <= 5; j++) begin
      cyc(1);
      chk("os_irq", {31'd0, irq1}, (j == 5) ? 1 : 0);
      if (j >= 2) chk("os_cnt", rdata1, 32'(5 - j));
    end
    cyc(3);
    chk("os_irq_hold", {31'd0, irq1}, 1);
    rd(0, v); chk("os_ctrl", v, 32'h8);
    wr(0, 0);
    chk("os_ack", {31'd0, irq1}, 0);

    // Auto-reload, PRESET=4, then PRESET=2 written mid-period
    rst(); wr(1, 4); wr(0, 32'hB);
    for (int j = 1; j <= 34; j++) begin
      if (j == 27) begin we = 1'b1; addr = 2'd1; wdata = 32'd2; end
      cyc(1);
      we = 1'b0;
      chk("ar_irq", {31'd0, irq1},
          ((j <= 24) ? (j % 6 == 0) : (j == 30 || j == 34)) ? 1 : 0);
    end
    wr(0, 0);

    // Masked one-shot
    rst(); wr(1, 2); wr(0, 32'h1);
    for (int j = 1; j <= 6; j++) begin cyc(1); chk("mask_irq", {31'd0, irq1}, 0); end
    rd(2, v); chk("mask_cnt", v, 0);
    rd(0, v); chk("mask_ctrl", v, 0);
    wr(0, 32'h8); cyc(2);
    chk("mask_noirq", {31'd0, irq1}, 0);

    // CTRL write in the same cycle as INT (one-shot)
    rst(); wr(1, 2); wr(0, 32'h9); cyc(3);
    chk("sim_pre", {31'd0, irq1}, 0);
    cyc(1);
    chk("sim_int", {31'd0, irq1}, 1);
    wr(0, 32'h9);
    chk("sim_nopend", {31'd0, irq1}, 0);
    rd(0, v); chk("sim_ctrl", v, 32'h9);
    wr(0, 0);

    // Stop at COUNT=7, read-only COUNT, unused address
    rst(); wr(1, 20); wr(0, 32'h1); cyc(14);
    rd(2, v); chk("stop_pre", v, 8);
    wr(0, 0);
    rd(2, v); chk("stop_7", v, 7);
    cyc(3);
    rd(2, v); chk("stop_hold", v, 7);
    wr(2, 32'hFFFF);
    rd(2, v); chk("cnt_ro", v, 7);
    wr(3, 32'h1234);
    rd(3, v); chk("addr3", v, 0);

    // Prescaler: PRESCALE=4 instance, PRESET=2
    rst(); wr(1, 2); wr(0, 32'h9);
    for (int j = 1; j <= 10; j++) begin
      cyc(1);
      chk("ps_irq", {31'd0, irq4}, (j == 10) ? 1 : 0);
    end
    cyc(2);
    chk("ps_hold", {31'd0, irq4}, 1);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer that is the interrupt source for the CPU's coprocessor-0 interrupt logic: it counts down from a programmed preset and asserts `irq`, which the system bridge routes onto one bit of the CPU's 6-bit `HWInt` vector. Software programs it through three word registers via `sw`/`lw` on the bridge. Two modes are supported: one-shot with a sticky level interrupt, and auto-reload with a one-cycle pulse per period.

## Interface
Parameters:
- `PRESCALE`, 1: clock cycles per count decrement. Legal range 1..65535.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `addr`  in  2  word select (bus address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=unused
- `we`  in  1  register write strobe, sampled at posedge
- `wdata`  in  32  write data
- `rdata`  out  32  read data, combinational from `addr`
- `irq`  out  1  interrupt request to the bridge/HWInt

## Operation
- Register map:
  - CTRL: [0] EN, [2:1] MODE, [3] IM, [31:4] read 0.
  - PRESET: 32-bit read/write.
  - COUNT: read-only; writes ignored.
  - addr 3: reads 0; writes ignored.
- MODE encoding: 0 = one-shot; 1 = auto-reload; 2 and 3 behave as 0.
- State machine `st`: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; prescale counter <= 0; go to CNT.
  - CNT:
    - If EN=0, go to IDLE with COUNT frozen.
    - Else, on each tick: if COUNT>1, COUNT <= COUNT-1; otherwise COUNT <= 0 and go to INT.
  - INT, MODE=1: go to LOAD.
  - INT, otherwise: hardware clears EN, sets `pend`, and goes to IDLE.
- Tick generation:
  - Prescale counter runs only in CNT, counting 0..PRESCALE-1.
  - Tick occurs when it equals PRESCALE-1, then it wraps to 0.
  - With PRESCALE=1, every CNT cycle is a tick.
- `pend` (mode-0 sticky flag):
  - Set on leaving INT in one-shot mode.
  - Cleared by any write to CTRL or PRESET, and by reset.
- `irq` = IM & (`pend` | (st==INT)).
  - Mode 1 produces a one-cycle pulse.
  - Mode 0 produces a level that rises when INT is entered and holds via `pend` until software acknowledges by writing.
- Writes take effect at the posedge:
  - A PRESET write does not disturb a running count; it is used at the next LOAD.
  - A CTRL write with EN=0 during CNT stops the count on the next edge.
  - A CTRL write with EN=1 while already in CNT does not restart the count.
- PRESET=0 behaves as PRESET=1, so the minimum count is one tick.

## Timing
- Reset values:
  - CTRL=0, PRESET=0, COUNT=0, `pend`=0, prescale counter=0, st=IDLE.
  - `irq`=0; `rdata`=0 for every `addr`.
- `rdata` shows the pre-write register value in the cycle of a write.
- Latency, with the EN=1 write at edge 0 and PRESCALE=1:
  - st=LOAD after edge 1; COUNT=PRESET (N) after edge 2.
  - COUNT=1 after edge N+1; COUNT=0, st=INT, `irq`=1 (if IM) after edge N+2.
  - With general PRESCALE: INT is entered after edge 2+N·PRESCALE.
- Mode-1 period: N·PRESCALE+2 cycles between `irq` pulses (INT→LOAD→CNT overhead of 2).
- Simultaneous events:
  - A software CTRL write in the same cycle st=INT beats the hardware EN clear; the written CTRL value is kept.
  - If that write is in one-shot mode, `pend` is still cleared and not set, so no level interrupt results.
  - In mode 1, a CTRL write with EN=0 in the same cycle as INT: next st is LOAD, then IDLE from CNT.
- Reset mid-count returns everything to reset values on that edge; `irq` drops the following cycle.

## Test plan
- Reset: assert reset during a mode-1 count with PRESET=5 -> after the edge, all reads return 0, `irq`=0, st=IDLE.
- One-shot:
  - Stimulus: PRESET=3, CTRL=0x9 (EN, IM, MODE 0), PRESCALE=1.
  - Required: COUNT reads 3,2,1,0 on consecutive cycles; `irq` rises exactly 5 cycles after the CTRL write edge and stays high; CTRL reads 0x8.
  - Acknowledge: write CTRL=0 -> `irq` low next cycle.
- Auto-reload:
  - Stimulus: PRESET=4, CTRL=0xB.
  - Required: `irq` 1-cycle pulses every 6 cycles for at least 4 periods.
  - Follow-up: write PRESET=2 mid-count -> the current period stays 6 and the next period is 4.
- Masking: PRESET=2, CTRL=0x1 (IM=0) -> `irq` never asserts; COUNT reaches 0; CTRL reads 0x0; a later CTRL write of IM=1 clears `pend`, so no spurious `irq`.
- Stop/bus edges:
  - Write CTRL EN=0 when COUNT=7 -> COUNT holds 7.
  - Write COUNT=0xFFFF -> ignored.
  - Read addr 3 -> 0.
- Prescaler: PRESCALE=4, PRESET=2, CTRL=0x9 -> `irq` rises 10 cycles after the write edge.
